prog_feeder: RTL and testbench

//  Upstream instruction source for the 8-bit CPU core.
//  - Captures a program byte stream from the host into an on-chip buffer.
//  - Serves that program back to the core: a registered instruction byte, indexed by the core's 6-bit PC.
//  - Sits between the host load interface and the core's ui_in instruction/immediate input.

---
 rtl/prog_feeder.sv | 117 +++++++++++
 tb/tb_prog_feeder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/prog_feeder.sv
// Program buffer between the host byte loader and the 8-bit core.
// Captures a program stream, then serves mem[pc] to the core one cycle later.
module prog_feeder #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic              load_last,
  input  logic [ADDR_W-1:0] pc,
  input  logic              send_ins,
  output logic [DATA_W-1:0] ins_out,
  output logic              ins_valid,
  output logic [ADDR_W:0]   prog_len,
  output logic              overflow,
  output logic              end_of_prog,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    HALT = 2'b11
  } state_t;

  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);

  state_t            state;
  logic [ADDR_W:0]   wr_ptr;
  logic [ADDR_W:0]   wr_nxt;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              take;
  logic              in_range;

  assign take      = load_valid & load_ready;
  assign wr_nxt    = wr_ptr + ONE;
  assign in_range  = {1'b0, pc} < prog_len;
  assign fsm_state = state;

  // Buffer is never cleared; reads past prog_len are zero-padded instead.
  always_ff @(posedge clk) begin
    if (take)
      mem[wr_ptr[AW-1:0]] <= load_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      prog_len    <= '0;
      ins_out     <= '0;
      ins_valid   <= 1'b0;
      load_ready  <= 1'b0;
      overflow    <= 1'b0;
      end_of_prog <= 1'b0;
      pc_q        <= '0;
    end else begin
      pc_q <= pc;
      unique case (state)
        IDLE: begin
          load_ready <= 1'b1;
          if (take) begin
            wr_ptr <= ONE;
            if (load_last) begin
              prog_len   <= ONE;
              load_ready <= 1'b0;
              state      <= RUN;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (take) begin
            wr_ptr     <= wr_nxt;
            load_ready <= wr_nxt < FULL;
            if (load_last) begin
              prog_len   <= wr_nxt;
              load_ready <= 1'b0;
              state      <= RUN;
            end
          end else if (load_valid) begin
            // Only reachable when full: the byte is dropped.
            overflow <= 1'b1;
            if (load_last) begin
              prog_len <= FULL;
              state    <= RUN;
            end
          end
        end
        RUN: begin
          ins_out   <= in_range ? mem[pc[AW-1:0]] : '0;
          ins_valid <= (pc == pc_q);
          if (!in_range && send_ins) begin
            ins_out     <= '0;
            ins_valid   <= 1'b1;
            end_of_prog <= 1'b1;
            state       <= HALT;
          end
        end
        HALT: begin
          ins_out   <= '0;
          ins_valid <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_feeder.sv
// Directed bench for prog_feeder: vector table for RUN reads,
// hand sequences for overflow, halt and mid-load reset.
module tb_prog_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_ready;
  logic       load_last = 1'b0;
  logic [5:0] pc = 6'd0;
  logic       send_ins = 1'b0;
  logic [7:0] ins_out;
  logic       ins_valid;
  logic [6:0] prog_len;
  logic       overflow;
  logic       end_of_prog;
  logic [1:0] fsm_state;

  int total = 0;
  int bad = 0;

  logic [7:0] prog [64];

  typedef struct {
    logic [5:0] pc;
    logic       send;
    logic [7:0] ins;
    logic       valid;
    logic [1:0] st;
  } vec_t;

  vec_t vt [16];

  prog_feeder dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_last(load_last),
    .pc(pc), .send_ins(send_ins),
    .ins_out(ins_out), .ins_valid(ins_valid),
    .prog_len(prog_len), .overflow(overflow),
    .end_of_prog(end_of_prog), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_ins", ins_out, 0);
    check("rst_valid", ins_valid, 0);
    check("rst_ready", load_ready, 0);
    check("rst_len", prog_len, 0);
    check("rst_ovf", overflow, 0);
    check("rst_eop", end_of_prog, 0);
    check("rst_state", fsm_state, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pc = 6'd0;
    send_ins = 1'b0;
    load_valid = 1'b0;
    load_last = 1'b0;
    #1 check_reset_vals();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Back-to-back bytes; returns at the negedge after the last accept.
  task automatic load(input int n, input bit last_end);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("load_ready", load_ready, 1);
      load_valid = 1'b1;
      load_data = prog[i];
      load_last = last_end && (i == n - 1);
      @(posedge clk);
    end
    @(negedge clk);
    load_valid = 1'b0;
    load_last = 1'b0;
  endtask

  task automatic run_vec(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      pc = vt[i].pc;
      send_ins = vt[i].send;
      @(negedge clk);
      check($sformatf("v%0d_ins", i), ins_out, vt[i].ins);
      check($sformatf("v%0d_valid", i), ins_valid, vt[i].valid);
      check($sformatf("v%0d_state", i), fsm_state, vt[i].st);
    end
  endtask

  initial begin
    vt[0]  = '{6'd0, 1'b0, 8'hA1, 1'b1, 2'd2};
    vt[1]  = '{6'd1, 1'b0, 8'hB2, 1'b0, 2'd2};
    vt[2]  = '{6'd1, 1'b0, 8'hB2, 1'b1, 2'd2};
    vt[3]  = '{6'd2, 1'b0, 8'hC3, 1'b0, 2'd2};
    vt[4]  = '{6'd2, 1'b0, 8'hC3, 1'b1, 2'd2};
    vt[5]  = '{6'd3, 1'b0, 8'h00, 1'b0, 2'd2};
    vt[6]  = '{6'd3, 1'b0, 8'h00, 1'b1, 2'd2};
    vt[7]  = '{6'd3, 1'b1, 8'h00, 1'b1, 2'd3};
    vt[8]  = '{6'd0, 1'b0, 8'h00, 1'b1, 2'd3};
    vt[9]  = '{6'd0, 1'b0, 8'h7F, 1'b1, 2'd2};
    vt[10] = '{6'd1, 1'b0, 8'h00, 1'b0, 2'd2};
    vt[11] = '{6'd1, 1'b1, 8'h00, 1'b1, 2'd3};

    // Reset values during power-on reset
    #3 check_reset_vals();
    @(negedge clk);
    rst = 1'b0;

    // Three-byte program, reads, zero pad, halt
    prog[0] = 8'hA1; prog[1] = 8'hB2; prog[2] = 8'hC3;
    load(3, 1'b1);
    check("t1_len", prog_len, 3);
    check("t1_state", fsm_state, 2);
    run_vec(0, 8);
    check("t3_eop", end_of_prog, 1);
    load_valid = 1'b1; load_last = 1'b1; load_data = 8'h55;
    @(negedge clk);
    load_valid = 1'b0; load_last = 1'b0;
    check("t3_ready", load_ready, 0);
    check("t3_len", prog_len, 3);
    check("t3_ovf", overflow, 0);
    check("t3_state", fsm_state, 3);
    check("t3_eop_hold", end_of_prog, 1);

    // Full buffer plus a dropped 65th byte with load_last
    do_reset();
    for (int i = 0; i < 64; i++) prog[i] = 8'(i * 3 + 1);
    load(64, 1'b0);
    check("t2_ready_full", load_ready, 0);
    check("t2_state_load", fsm_state, 1);
    check("t2_ovf_pre", overflow, 0);
    load_valid = 1'b1; load_last = 1'b1; load_data = 8'hEE;
    @(negedge clk);
    load_valid = 1'b0; load_last = 1'b0;
    check("t2_ovf", overflow, 1);
    check("t2_len", prog_len, 64);
    check("t2_state", fsm_state, 2);
    pc = 6'd63;
    @(negedge clk); @(negedge clk);
    check("t2_ins63", ins_out, 8'hBE);
    check("t2_valid63", ins_valid, 1);

    // Reset mid-load, then a two-byte reload
    do_reset();
    for (int i = 0; i < 5; i++) prog[i] = 8'h90 + 8'(i);
    load(5, 1'b0);
    check("t4_state_load", fsm_state, 1);
    do_reset();
    prog[0] = 8'h11; prog[1] = 8'h22;
    load(2, 1'b1);
    check("t4_len", prog_len, 2);
    check("t4_state", fsm_state, 2);
    pc = 6'd1;
    @(negedge clk); @(negedge clk);
    check("t4_ins1", ins_out, 8'h22);
    check("t4_valid1", ins_valid, 1);
    pc = 6'd2;
    @(negedge clk);
    check("t4_pad", ins_out, 8'h00);

    // Single byte carrying load_last straight from IDLE
    do_reset();
    prog[0] = 8'h7F;
    load(1, 1'b1);
    check("t6_len", prog_len, 1);
    check("t6_state", fsm_state, 2);
    run_vec(9, 11);
    check("t6_eop", end_of_prog, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
